// File: rtl/decoder_seq_pkg.sv
// ----------------------------------------------------------------------------
// decoder_seq_pkg
//
// Shared types for the sequential one-hot select generator.
//   mode_e  : command mode carried on in_mode (OFF / DIRECT / SCAN_UP / SCAN_DOWN)
//   state_e : controller state (IDLE / HOLD / SCAN / BLANK)
//
// BLANK is only ever entered when DECODER_SEQ_BLANK_EN is defined; the
// encoding is kept in both builds so the type stays the same everywhere.
// ----------------------------------------------------------------------------
package decoder_seq_pkg;

  // Raw 2-bit encodings of the command modes, usable where a plain vector
  // is handier than the enum (e.g. register maps upstream).
  localparam logic [1:0] MODE_ENC_OFF       = 2'b00;
  localparam logic [1:0] MODE_ENC_DIRECT    = 2'b01;
  localparam logic [1:0] MODE_ENC_SCAN_UP   = 2'b10;
  localparam logic [1:0] MODE_ENC_SCAN_DOWN = 2'b11;

  typedef enum logic [1:0] {
    MODE_OFF       = MODE_ENC_OFF,
    MODE_DIRECT    = MODE_ENC_DIRECT,
    MODE_SCAN_UP   = MODE_ENC_SCAN_UP,
    MODE_SCAN_DOWN = MODE_ENC_SCAN_DOWN
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD  = 2'b01,
    ST_SCAN  = 2'b10,
    ST_BLANK = 2'b11
  } state_e;

  // Both scan modes have the top encoding bit set.
  function automatic logic is_scan_mode(input mode_e m);
    return m[1];
  endfunction

  // Direction of a scan mode: 1 = counting up.
  function automatic logic is_scan_up(input mode_e m);
    return (m == MODE_SCAN_UP);
  endfunction

endpackage

// File: rtl/decoder_seq_if.sv
// ----------------------------------------------------------------------------
// decoder_seq_if
//
// Command handshake and select outputs of decoder_seq bundled together.
//   in_valid  : command present                     (master -> slave)
//   in_ready  : command can be accepted this cycle  (slave  -> master)
//   in_mode   : OFF / DIRECT / SCAN_UP / SCAN_DOWN  (master -> slave)
//   in_sel    : target or start index               (master -> slave)
//   in_dwell  : extra cycles per scan position      (master -> slave)
//   dout      : registered one-hot select           (slave  -> master)
//   busy      : high while scanning                 (slave  -> master)
//   wrap      : one-cycle scan wrap-around pulse    (slave  -> master)
//
// The "master" modport is the control register block side, "slave" is the
// select generator itself.
// ----------------------------------------------------------------------------
interface decoder_seq_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
);
  import decoder_seq_pkg::*;

  localparam int OUT_W = 2 ** SEL_W;

  logic               in_valid;
  logic               in_ready;
  mode_e              in_mode;
  logic [SEL_W-1:0]   in_sel;
  logic [DWELL_W-1:0] in_dwell;
  logic [OUT_W-1:0]   dout;
  logic               busy;
  logic               wrap;

  modport master (
    output in_valid,
    output in_mode,
    output in_sel,
    output in_dwell,
    input  in_ready,
    input  dout,
    input  busy,
    input  wrap
  );

  modport slave (
    input  in_valid,
    input  in_mode,
    input  in_sel,
    input  in_dwell,
    output in_ready,
    output dout,
    output busy,
    output wrap
  );

endinterface

// File: rtl/decoder_seq_onehot_dec.sv
// ----------------------------------------------------------------------------
// onehot_dec
//
// Purely combinational SEL_W -> 2**SEL_W one-hot decoder. Because the output
// width is exactly 2**SEL_W, every index value maps to a real output line and
// the result is always exactly one-hot.
//   idx    : index to decode
//   onehot : one-hot vector with bit idx set
// ----------------------------------------------------------------------------
module onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      idx,
  output logic [2**SEL_W-1:0]   onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/decoder_seq.sv
// ----------------------------------------------------------------------------
// decoder_seq
//
// Registered one-hot select generator for the row/column select drivers.
// Drives 2**SEL_W select lines either held at a commanded index (DIRECT) or
// auto-scanned up/down with a programmable dwell per position (SCAN_UP /
// SCAN_DOWN). Commands arrive over a valid/ready handshake and preempt
// whatever is running.
//
// Parameters:
//   SEL_W   : index width, output count is 2**SEL_W
//   DWELL_W : width of the dwell field
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : decoder_seq_if.slave (in_valid/in_ready/in_mode/in_sel/in_dwell,
//         dout/busy/wrap)
//
// Optional build macro:
//   DECODER_SEQ_BLANK_EN : break-before-make. Every index change while a
//   select is active passes through one BLANK cycle (dout=0, in_ready=0).
//   Scan period per position becomes dwell+2 instead of dwell+1.
// ----------------------------------------------------------------------------
module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  decoder_seq_if.slave bus
);

  localparam int OUT_W = 2 ** SEL_W;

  localparam logic [SEL_W-1:0]   IDX_ONE   = SEL_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  // Registered state
  state_e             state_q;
  logic [SEL_W-1:0]   idx_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               up_q;
  logic [OUT_W-1:0]   dout_q;
  logic               busy_q;
  logic               wrap_q;

  // Next-state values
  state_e             state_n;
  logic [SEL_W-1:0]   idx_n;
  logic [DWELL_W-1:0] cnt_n;
  logic [DWELL_W-1:0] dwell_n;
  logic               up_n;
  logic               wrap_n;
  logic               step_wrap;
  logic [OUT_W-1:0]   sel_onehot;
  logic               accept;

`ifdef DECODER_SEQ_BLANK_EN
  // While blanking, idx_q already holds the upcoming index; these remember
  // which state to resume and whether that first visible cycle is a wrap.
  state_e pend_q;
  state_e pend_n;
  logic   wrap_pend_q;
  logic   wrap_pend_n;
`endif

  // in_ready drops combinationally with rst so nothing is accepted during
  // reset, and stays low through a blank cycle.
  assign bus.in_ready = !rst && (state_q != ST_BLANK);
  assign accept       = bus.in_valid && bus.in_ready;

  // Decode the index that will be shown after the edge, then register it;
  // dout is therefore a clean flop output with no decode glitches.
  onehot_dec #(
    .SEL_W (SEL_W)
  ) u_onehot_dec (
    .idx    (idx_n),
    .onehot (sel_onehot)
  );

  // Next-state logic. A command always wins over the scan step on the same
  // edge, which is what makes preemption restart the dwell without a wrap.
  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    cnt_n     = cnt_q;
    dwell_n   = dwell_q;
    up_n      = up_q;
    wrap_n    = 1'b0;
    step_wrap = 1'b0;
`ifdef DECODER_SEQ_BLANK_EN
    pend_n      = pend_q;
    wrap_pend_n = wrap_pend_q;
`endif

    if (accept) begin
      if (bus.in_mode == MODE_OFF) begin
        state_n = ST_IDLE;
      end else if (bus.in_mode == MODE_DIRECT) begin
        state_n = ST_HOLD;
        idx_n   = bus.in_sel;
      end else begin
        state_n = ST_SCAN;
        idx_n   = bus.in_sel;
        cnt_n   = bus.in_dwell;
        dwell_n = bus.in_dwell;
        up_n    = is_scan_up(bus.in_mode);
      end
`ifdef DECODER_SEQ_BLANK_EN
      // Replacing an active select goes through a blank first; commands
      // from IDLE (nothing lit) and OFF commands go straight through.
      if ((bus.in_mode != MODE_OFF) && (state_q != ST_IDLE)) begin
        pend_n      = state_n;
        state_n     = ST_BLANK;
        wrap_pend_n = 1'b0;
      end
`endif
    end else if (state_q == ST_SCAN) begin
      if (cnt_q == '0) begin
        // Wrap is judged on the index being left, before the step.
        step_wrap = up_q ? (idx_q == '1) : (idx_q == '0);
        idx_n     = up_q ? (idx_q + IDX_ONE) : (idx_q - IDX_ONE);
        cnt_n     = dwell_q;
`ifdef DECODER_SEQ_BLANK_EN
        state_n     = ST_BLANK;
        pend_n      = ST_SCAN;
        wrap_pend_n = step_wrap;
`else
        wrap_n      = step_wrap;
`endif
      end else begin
        cnt_n = cnt_q - DWELL_ONE;
      end
    end
`ifdef DECODER_SEQ_BLANK_EN
    else if (state_q == ST_BLANK) begin
      // The pending wrap is released together with the first lit cycle.
      state_n     = pend_q;
      wrap_n      = wrap_pend_q;
      wrap_pend_n = 1'b0;
    end
`endif
  end

  // State and output registers. Reset beats any command or step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      up_q    <= 1'b0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      cnt_q   <= cnt_n;
      dwell_q <= dwell_n;
      up_q    <= up_n;
      dout_q  <= ((state_n == ST_HOLD) || (state_n == ST_SCAN)) ? sel_onehot : '0;
      busy_q  <= (state_n == ST_SCAN);
      wrap_q  <= wrap_n;
    end
  end

`ifdef DECODER_SEQ_BLANK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= ST_IDLE;
      wrap_pend_q <= 1'b0;
    end else begin
      pend_q      <= pend_n;
      wrap_pend_q <= wrap_pend_n;
    end
  end
`endif

  assign bus.dout = dout_q;
  assign bus.busy = busy_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder_seq.sv
// ----------------------------------------------------------------------------
// tb_decoder_seq
//
// Self-checking bench for decoder_seq. The driver issues one command slot per
// cycle and pushes the expected post-edge outputs into a scoreboard queue; a
// monitor pops one entry per cycle and compares dout/busy/wrap/in_ready.
// The reference model describes each command by its start cycle and derives
// the visible index arithmetically from the elapsed cycle count.
// Honours DECODER_SEQ_BLANK_EN when defined.
// ----------------------------------------------------------------------------
module tb_decoder_seq;
  import decoder_seq_pkg::*;

  localparam int SEL_W   = 3;
  localparam int DWELL_W = 8;
  localparam int OUT_W   = 2 ** SEL_W;

`ifdef DECODER_SEQ_BLANK_EN
  localparam int BLANK_B = 1;
`else
  localparam int BLANK_B = 0;
`endif

  typedef struct {
    logic [OUT_W-1:0] dout;
    logic             busy;
    logic             wrap;
    logic             ready;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  decoder_seq_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

  decoder_seq #(
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  // Reference model: 0 = off/idle, 1 = direct, 2 = scan
  int   m_mode  = 0;
  int   m_sel   = 0;
  int   m_dwell = 0;
  bit   m_up    = 1'b0;
  bit   m_pre   = 1'b0;
  int   m_t     = 0;
  bit   m_blank = 1'b0;
  exp_t cur;

  function automatic exp_t predict(input bit r);
    exp_t e;
    int   o, p, k, rr, pos;
    bit   blank;
    e.dout  = '0;
    e.busy  = 1'b0;
    e.wrap  = 1'b0;
    blank   = 1'b0;
    if (!r) begin
      if (m_mode == 1) begin
        if (m_pre && m_t == 0) blank = 1'b1;
        else e.dout[m_sel] = 1'b1;
      end else if (m_mode == 2) begin
        o = m_t - (m_pre ? 1 : 0);
        if (o < 0) begin
          blank = 1'b1;
        end else begin
          p  = m_dwell + 1 + BLANK_B;
          k  = o / p;
          rr = o % p;
          if (rr > m_dwell) begin
            blank = 1'b1;
          end else begin
            pos = m_up ? ((m_sel + k) % OUT_W)
                       : ((m_sel - (k % OUT_W) + OUT_W) % OUT_W);
            e.dout[pos] = 1'b1;
            e.busy      = 1'b1;
            e.wrap      = (k > 0) && (rr == 0) &&
                          (m_up ? (pos == 0) : (pos == OUT_W - 1));
          end
        end
      end
    end
    m_blank = blank;
    e.ready = !r && !blank;
    return e;
  endfunction

  // Drive one cycle of inputs, update the model, push the expectation.
  task automatic applyStimulus(input bit r, input bit v, input mode_e md,
                               input int sel, input int dw);
    bit ready_now;
    rst          = r;
    bus.in_valid = v;
    bus.in_mode  = md;
    bus.in_sel   = SEL_W'(sel);
    bus.in_dwell = DWELL_W'(dw);
    ready_now    = !r && !m_blank;
    if (r) begin
      m_mode = 0;
      m_pre  = 1'b0;
      m_t    = 0;
    end else if (v && ready_now) begin
      m_pre   = (BLANK_B == 1) && (md != MODE_OFF) && (cur.dout != '0);
      m_sel   = sel % OUT_W;
      m_dwell = dw % (1 << DWELL_W);
      m_up    = (md == MODE_SCAN_UP);
      m_mode  = (md == MODE_OFF) ? 0 : (md == MODE_DIRECT) ? 1 : 2;
      m_t     = 0;
    end else begin
      m_t = m_t + 1;
    end
    cur = predict(r);
    sb.push_back(cur);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, MODE_OFF, 0, 0);
  endtask

  task automatic cmd(input mode_e md, input int sel, input int dw);
    applyStimulus(1'b0, 1'b1, md, sel, dw);
  endtask

  task automatic checkOutput(input exp_t e);
    total++;
    if (bus.dout !== e.dout) begin
      bad++;
      $display("[TB] FAIL dout at %0t: got %b want %b", $time, bus.dout, e.dout);
    end
    total++;
    if (bus.busy !== e.busy) begin
      bad++;
      $display("[TB] FAIL busy at %0t: got %b want %b", $time, bus.busy, e.busy);
    end
    total++;
    if (bus.wrap !== e.wrap) begin
      bad++;
      $display("[TB] FAIL wrap at %0t: got %b want %b", $time, bus.wrap, e.wrap);
    end
    total++;
    if (bus.in_ready !== e.ready) begin
      bad++;
      $display("[TB] FAIL in_ready at %0t: got %b want %b", $time, bus.in_ready, e.ready);
    end
  endtask

  // Monitor: one scoreboard entry per clock, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit    r, v;
    mode_e md;
    int    sel, dw;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_mode  = MODE_OFF;
    bus.in_sel   = '0;
    bus.in_dwell = '0;
    cur          = predict(1'b1);
    @(posedge clk);
    #2;

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, MODE_OFF, 0, 0);

    $display("[TB] direct hold and index sweep");
    cmd(MODE_DIRECT, 5, 9);
    idle(5);
    for (int i = 0; i < OUT_W; i++) begin
      cmd(MODE_DIRECT, i, 0);
      idle(1);
    end

    $display("[TB] scan up from 6, dwell 2");
    cmd(MODE_SCAN_UP, 6, 2);
    idle(14);

    $display("[TB] scan down from 1, dwell 0");
    cmd(MODE_SCAN_DOWN, 1, 0);
    idle(10);

    $display("[TB] scan up from 0 (no wrap on load)");
    cmd(MODE_OFF, 0, 0);
    idle(1);
    cmd(MODE_SCAN_UP, 0, 1);
    idle(6);

    $display("[TB] mid-scan off and back-to-back preemption");
    cmd(MODE_OFF, 0, 0);
    idle(2);
    cmd(MODE_SCAN_UP, 7, 3);
    cmd(MODE_SCAN_DOWN, 0, 1);
    idle(5);
    cmd(MODE_DIRECT, 3, 0);
    idle(2);

    $display("[TB] reset mid-scan with a command on the same edge");
    cmd(MODE_SCAN_DOWN, 4, 0);
    idle(3);
    applyStimulus(1'b1, 1'b1, MODE_DIRECT, 2, 0);
    applyStimulus(1'b1, 1'b0, MODE_OFF, 0, 0);
    idle(2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 800; i++) begin
      r   = ($urandom_range(0, 79) == 0);
      v   = ($urandom_range(0, 5) == 0);
      md  = mode_e'($urandom_range(0, 3));
      sel = $urandom_range(0, OUT_W - 1);
      dw  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 2);
      applyStimulus(r, v, md, sel, dw);
    end
    idle(3);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d entries left want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
# decoder_seq

Parametrised, registered one-hot select generator: the sequential successor to the plain 3-to-8 decoder. It drives 2^SEL_W one-hot lines, either held at a commanded index or auto-scanned up or down with a programmable dwell per position. It sits in the video display processor between the control register block and the row/column select drivers, and accepts commands over a valid/ready handshake.

## Interface
- SEL_W, 3: index width; output count OUT_W = 2**SEL_W (derived localparam, not overridable).
- DWELL_W, 8: width of the dwell field.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command present.
- in_ready  out  1  command can be accepted this cycle.
- in_mode  in  2  00 OFF, 01 DIRECT, 10 SCAN_UP, 11 SCAN_DOWN.
- in_sel  in  SEL_W  target index (DIRECT) or start index (SCAN).
- in_dwell  in  DWELL_W  extra cycles each scan position is held; ignored in DIRECT/OFF.
- dout  out  OUT_W  registered one-hot select (all-zero when off or blanking).
- busy  out  1  high while in SCAN state.
- wrap  out  1  one-cycle pulse on scan wrap-around.

## Operation
- States: IDLE (dout=0), HOLD (static one-hot), SCAN (stepping), BLANK (present only with macro, see Configuration).
- Command accepted on an edge where in_valid & in_ready; in_mode, in_sel and in_dwell are latched on that edge.
- OFF -> IDLE. DIRECT -> HOLD with idx=in_sel. SCAN_UP/SCAN_DOWN -> SCAN with idx=in_sel, dwell counter loaded with in_dwell.
- SCAN: when dwell counter is 0, idx steps (+1 or -1, modulo OUT_W) and counter reloads from the latched dwell; otherwise it decrements. Each position is held in_dwell+1 cycles; in_dwell=0 steps every cycle.
- wrap asserts for exactly the cycle in which dout first shows the wrapped index (UP: OUT_W-1 -> 0; DOWN: 0 -> OUT_W-1). No wrap pulse on command load, even if in_sel is 0.
- New command accepted in any state preempts the current one immediately; the dwell counter restarts and no wrap is generated.
- dout is always exactly one-hot in HOLD/SCAN and all-zero in IDLE/BLANK; never multi-hot.
- Index arithmetic is SEL_W bits with natural modulo wrap; no out-of-range index exists.

## Timing
- Reset (rst high at an edge): dout=0, busy=0, wrap=0, state IDLE, idx=0, counter=0; in_ready=0 while rst is high.
- Command latency 1 cycle: accepted at edge k, new dout visible after edge k.
- in_ready=1 in IDLE, HOLD and SCAN; 0 only in BLANK and during reset.
- busy registered alongside dout: high after the edge that enters SCAN, low after the edge that leaves it.
- Reset mid-scan takes priority over any command or step on the same edge.

## Configuration
- DECODER_SEQ_BLANK_EN defined: break-before-make. Every index change while dout is non-zero (scan step, or DIRECT/SCAN command replacing an active select) first passes one BLANK cycle with dout=0 and in_ready=0; the new one-hot appears the following cycle. Scan period per position becomes in_dwell+2. wrap pulses with the first non-zero cycle after the wrap blank. Commands from IDLE incur no blank.
- Not defined: no BLANK state; indices switch directly one-hot to one-hot, period in_dwell+1.

## Structure
- decoder_seq_pkg: mode enum (OFF/DIRECT/SCAN_UP/SCAN_DOWN), state enum (IDLE/HOLD/SCAN/BLANK), mode encoding constants.
- Sub-module onehot_dec (parameter SEL_W): combinational idx -> OUT_W one-hot; instantiated once, output registered in decoder_seq.

## Test plan
- Reset then DIRECT, in_sel=5 -> dout=8'b0010_0000 one cycle after accept, busy=0, holds indefinitely; sweep all 8 indices and check one-hot.
- SCAN_UP, in_sel=6, in_dwell=2 -> dout index 6,6,6,7,7,7,0,... ; wrap high only on the first cycle of index 0; busy=1.
- SCAN_DOWN, in_sel=1, in_dwell=0 -> index 1,0,7,6 on successive cycles; wrap exactly on the cycle of 7.
- Mid-scan OFF command -> dout=0 and busy=0 one cycle after accept; rst asserted mid-scan -> all outputs zero next edge, in_ready=0 while rst high.
- DECODER_SEQ_BLANK_EN, SCAN_UP in_sel=0 in_dwell=1 -> 0,0,blank,1,1,blank,2...; in_ready=0 only on blank cycles; DIRECT 3 while index 2 active -> one zero cycle, then 8'b0000_1000.
- SEL_W=4 build -> 16 outputs, SCAN_UP from 15 wraps to 0 with a single wrap pulse.
